// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_fetch_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   typedef enum logic [1:0] {
      FLT_NONE     = 2'd0,
      FLT_MISALIGN = 2'd1,
      FLT_OOR      = 2'd2
   } fetch_fault_e;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
   localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, drives the ROM address, registers the
// returned word into a fetch packet for the decoder, applies redirects and
// halts on misaligned or out-of-range fetch addresses.
module instr_fetch_unit
   import riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS = 129
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] instr_rAddr,
   input  logic [31:0] instr_code,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_pc_plus4,
   output logic [31:0] dec_instr,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic [31:0] fault_pc,
   output logic [31:0] fetch_cnt
);

   // First byte address past the end of the ROM.
   localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

   fetch_state_e state_q, state_d;
   fetch_fault_e cause_q, cause_d;
   logic [31:0]  pc_q, pc_d;
   logic         valid_q, valid_d;
   logic [31:0]  dpc_q, dpc_d;
   logic [31:0]  dpc4_q, dpc4_d;
   logic [31:0]  dinstr_q, dinstr_d;
   logic         fault_q, fault_d;
   logic [31:0]  fpc_q, fpc_d;
   logic [31:0]  cnt_q, cnt_d;

   logic take;
   logic oor;
   logic hs;

   assign take = !valid_q || dec_ready;
   assign oor  = (pc_q >= PC_LIMIT);
   assign hs   = valid_q && dec_ready;

   // Next-state selection: redirect beats fetch, fetch beats stall.
   always_comb begin
      state_d  = state_q;
      cause_d  = cause_q;
      pc_d     = pc_q;
      valid_d  = valid_q;
      dpc_d    = dpc_q;
      dpc4_d   = dpc4_q;
      dinstr_d = dinstr_q;
      fault_d  = fault_q;
      fpc_d    = fpc_q;
      cnt_d    = cnt_q + {31'd0, hs};

      case (state_q)
         RUN: begin
            if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
               valid_d = 1'b0;
               fault_d = 1'b1;
               cause_d = FLT_MISALIGN;
               fpc_d   = redirect_target;
               state_d = HALT;
            end else if (redirect_valid) begin
               // Flush the held packet; the word read this cycle is dropped.
               valid_d = 1'b0;
               pc_d    = redirect_target;
            end else if (take && oor) begin
               valid_d = 1'b0;
               fault_d = 1'b1;
               cause_d = FLT_OOR;
               fpc_d   = pc_q;
               state_d = HALT;
            end else if (take) begin
               valid_d  = 1'b1;
               dpc_d    = pc_q;
               dpc4_d   = pc_q + PC_STEP;
               dinstr_d = instr_code;
               pc_d     = pc_q + PC_STEP;
            end
         end
         HALT: begin
            // Only drain the last packet; no new fetches, redirects ignored.
            if (hs) valid_d = 1'b0;
         end
         default: begin
            state_d = HALT;
         end
      endcase
   end

   // State register: synchronous reset overrides all other inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= RUN;
         cause_q  <= FLT_NONE;
         pc_q     <= RESET_PC;
         valid_q  <= 1'b0;
         dpc_q    <= '0;
         dpc4_q   <= '0;
         dinstr_q <= INSTR_NOP;
         fault_q  <= 1'b0;
         fpc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         cause_q  <= cause_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         dpc_q    <= dpc_d;
         dpc4_q   <= dpc4_d;
         dinstr_q <= dinstr_d;
         fault_q  <= fault_d;
         fpc_q    <= fpc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign instr_rAddr  = pc_q;
   assign dec_valid    = valid_q;
   assign dec_pc       = dpc_q;
   assign dec_pc_plus4 = dpc4_q;
   assign dec_instr    = dinstr_q;
   assign fault        = fault_q;
   assign fault_cause  = cause_q;
   assign fault_pc     = fpc_q;
   assign fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic, with
// a queue-based reference model and a negedge monitor.
module tb_instr_fetch_unit;
   import riscv_fetch_pkg::*;

   localparam int unsigned WORDS = 129;
   localparam logic [31:0] LIMIT = 32'(WORDS * 4);

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
   } pkt_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr_rAddr;
   logic [31:0] instr_code;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        dec_valid;
   logic        dec_ready = 1'b1;
   logic [31:0] dec_pc, dec_pc_plus4, dec_instr;
   logic        fault;
   logic [1:0]  fault_cause;
   logic [31:0] fault_pc, fetch_cnt;

   logic [31:0] rom [WORDS];

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(WORDS)) dut (
      .clk(clk), .reset(reset), .instr_rAddr(instr_rAddr), .instr_code(instr_code),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
      .dec_pc_plus4(dec_pc_plus4), .dec_instr(dec_instr), .fault(fault),
      .fault_cause(fault_cause), .fault_pc(fault_pc), .fetch_cnt(fetch_cnt)
   );

   // Behavioural ROM: combinational read, garbage outside the array.
   always_comb begin
      instr_code = 32'hDEAD_BEEF;
      if (instr_rAddr < LIMIT && instr_rAddr[1:0] == 2'b00)
         instr_code = rom[int'(instr_rAddr >> 2)];
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: next fetch address, pending packet queue, fault record.
   logic [31:0] m_pc;
   bit          m_halt;
   logic [31:0] m_fault, m_cause, m_fpc, m_cnt;
   pkt_t        exp_q[$];
   pkt_t        m_last;
   bit          mon_en = 1'b0;

   task automatic model_step(input bit rst, input bit rv, input logic [31:0] tgt, input bit rdy);
      bit consumed;
      if (rst) begin
         m_pc = 32'h0; m_halt = 0; m_fault = 0; m_cause = 0; m_fpc = 0; m_cnt = 0;
         exp_q.delete();
         m_last = '{pc: 32'h0, pc4: 32'h0, instr: INSTR_NOP};
         return;
      end
      consumed = (exp_q.size() != 0) && rdy;
      if (consumed) m_cnt++;
      if (m_halt) begin
         if (consumed) void'(exp_q.pop_front());
      end else if (rv && tgt[1:0] != 2'b00) begin
         exp_q.delete();
         m_fault = 1; m_cause = 1; m_fpc = tgt; m_halt = 1;
      end else if (rv) begin
         exp_q.delete();
         m_pc = tgt;
      end else if (exp_q.size() == 0 || rdy) begin
         if (consumed) void'(exp_q.pop_front());
         if (m_pc >= LIMIT) begin
            m_fault = 1; m_cause = 2; m_fpc = m_pc; m_halt = 1;
         end else begin
            m_last = '{pc: m_pc, pc4: m_pc + 32'd4, instr: rom[int'(m_pc >> 2)]};
            exp_q.push_back(m_last);
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   // Monitor: compare DUT outputs with the model once per cycle.
   initial begin
      pkt_t p;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("instr_rAddr", instr_rAddr, m_pc);
            chk("dec_valid", {31'd0, dec_valid}, {31'd0, exp_q.size() != 0});
            p = (exp_q.size() != 0) ? exp_q[0] : m_last;
            chk("dec_pc", dec_pc, p.pc);
            chk("dec_pc_plus4", dec_pc_plus4, p.pc4);
            chk("dec_instr", dec_instr, p.instr);
            chk("fault", {31'd0, fault}, m_fault);
            chk("fault_cause", {30'd0, fault_cause}, m_cause);
            chk("fault_pc", fault_pc, m_fpc);
            chk("fetch_cnt", fetch_cnt, m_cnt);
         end
      end
   end

   // One clock of stimulus: drive, advance the model, wait past the edge.
   task automatic cycle(input bit rst, input bit rv, input logic [31:0] tgt, input bit rdy);
      reset = rst; redirect_valid = rv; redirect_target = tgt; dec_ready = rdy;
      model_step(rst, rv, tgt, rdy);
      if (rst) mon_en = 1'b1;
      @(negedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          r_rst, r_rv, r_rdy;
      logic [31:0] t;
      for (int i = 0; i < int'(WORDS); i++) rom[i] = $urandom;
      rom[0] = 32'h00C5_0593; rom[1] = 32'hFF45_0593;
      rom[2] = 32'h00C6_A593; rom[3] = 32'hFF46_A593;

      @(negedge clk); #1;
      cycle(1, 0, 0, 1);
      cycle(1, 0, 0, 1);
      chk("rst_dec_instr", dec_instr, 32'h0000_0013);
      chk("rst_rAddr", instr_rAddr, 32'h0);

      // Sequential fetch
      cycle(0, 0, 0, 1);
      chk("seq_first_instr", dec_instr, 32'h00C5_0593);
      chk("seq_first_pc", dec_pc, 32'h0);
      cycle(0, 0, 0, 1);
      chk("seq_second_instr", dec_instr, 32'hFF45_0593);
      chk("seq_second_pc4", dec_pc_plus4, 32'h8);
      repeat (3) cycle(0, 0, 0, 1);
      chk("seq_cnt", fetch_cnt, 32'd4);

      // Back-pressure
      cycle(1, 0, 0, 1);
      repeat (3) cycle(0, 0, 0, 1);
      repeat (3) cycle(0, 0, 0, 0);
      chk("bp_pc", dec_pc, 32'h8);
      chk("bp_instr", dec_instr, 32'h00C6_A593);
      chk("bp_rAddr", instr_rAddr, 32'hC);
      cycle(0, 0, 0, 1);
      chk("bp_next_pc", dec_pc, 32'hC);
      chk("bp_cnt", fetch_cnt, 32'd3);

      // Redirect while stalled
      cycle(1, 0, 0, 1);
      repeat (2) cycle(0, 0, 0, 1);
      cycle(0, 1, 32'h14, 0);
      chk("rd_valid", {31'd0, dec_valid}, 32'd0);
      chk("rd_rAddr", instr_rAddr, 32'h14);
      chk("rd_cnt", fetch_cnt, 32'd1);
      cycle(0, 0, 0, 1);
      chk("rd_pkt_pc", dec_pc, 32'h14);

      // Misaligned redirect, then ignored redirect, then reset
      cycle(0, 1, 32'h16, 1);
      chk("mis_fault", {31'd0, fault}, 32'd1);
      chk("mis_cause", {30'd0, fault_cause}, 32'd1);
      chk("mis_fpc", fault_pc, 32'h16);
      cycle(0, 1, 32'h0, 1);
      cycle(0, 0, 0, 1);
      chk("mis_halt_rAddr", instr_rAddr, 32'h18);
      chk("mis_halt_valid", {31'd0, dec_valid}, 32'd0);
      cycle(1, 0, 0, 1);
      chk("mis_clear", {29'd0, fault, fault_cause}, 32'd0);

      // Out of range at the top of the ROM
      cycle(0, 1, 32'h1F8, 1);
      repeat (3) cycle(0, 0, 0, 1);
      chk("oor_last_pc", dec_pc, 32'h200);
      cycle(0, 0, 0, 1);
      chk("oor_cause", {30'd0, fault_cause}, 32'd2);
      chk("oor_fpc", fault_pc, LIMIT);

      // Reset mid-stream with a simultaneous redirect
      cycle(1, 0, 0, 1);
      repeat (2) cycle(0, 0, 0, 1);
      cycle(1, 1, 32'h40, 1);
      chk("rm_rAddr", instr_rAddr, 32'h0);
      chk("rm_valid", {31'd0, dec_valid}, 32'd0);
      chk("rm_cnt", fetch_cnt, 32'd0);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         r_rst = m_halt ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 80) == 0);
         r_rv  = ($urandom_range(0, 7) == 0);
         t     = 32'($urandom_range(0, 134)) << 2;
         if ($urandom_range(0, 4) == 0) t[1:0] = 2'($urandom_range(1, 3));
         r_rdy = ($urandom_range(0, 3) != 0);
         cycle(r_rst, r_rv, t, r_rdy);
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
